// File: rtl/cardinal_nic_vcq.sv
// cardinal_nic_vcq -- NIC between a PE and its cardinal router port.
//
// One DEPTH-entry input FIFO (router -> PE) and two DEPTH-entry output
// queues, one per virtual channel (PE -> router). The output VC of a PE
// write is taken from d_in[0]. Only the queue matching ~net_polarity is
// offered to the router, so a stalled VC never blocks the other one.
//
// Optional build macro: CARDINAL_NIC_OVF_EN
//   defined   : sticky in/out overflow flags, cleared by reading their
//               status register (set wins over clear in the same cycle).
//   undefined : no flag registers, flag bits read 0.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   addr          00 in-data, 01 in-status, 10 out-data, 11 out-status
//   d_in / d_out  PE write data / PE read data (combinational)
//   nicEn         PE access enable
//   nicWrEn       1 = write, 0 = read
//   net_si/net_ri/net_di   router -> NIC send / ready / packet
//   net_so/net_ro/net_do   NIC -> router send / ready / packet
//   net_polarity  router polarity (1 sends VC0, 0 sends VC1)
module cardinal_nic_vcq #(
  parameter int PAC_WIDTH = 64,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           addr,
  input  logic [PAC_WIDTH-1:0] d_in,
  output logic [PAC_WIDTH-1:0] d_out,
  input  logic                 nicEn,
  input  logic                 nicWrEn,
  input  logic                 net_si,
  output logic                 net_ri,
  input  logic [PAC_WIDTH-1:0] net_di,
  output logic                 net_so,
  input  logic                 net_ro,
  output logic [PAC_WIDTH-1:0] net_do,
  input  logic                 net_polarity
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // ---------------------------------------------------------------
  // Input FIFO (router -> PE)
  // ---------------------------------------------------------------
  logic [PAC_WIDTH-1:0] in_mem [DEPTH];
  logic [AW-1:0]        in_wp, in_rp;
  logic [AW:0]          in_cnt;
  logic                 in_full, in_empty, in_push, in_pop, pe_rd;

  assign pe_rd    = nicEn & ~nicWrEn;
  assign in_full  = (in_cnt == FULL_CNT);
  assign in_empty = (in_cnt == '0);
  // Ready comes from the registered count only; a same-cycle PE pop
  // does not open a slot for the router.
  assign net_ri   = ~in_full;
  assign in_push  = net_si & ~in_full;
  assign in_pop   = pe_rd & (addr == 2'b00) & ~in_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_wp  <= '0;
      in_rp  <= '0;
      in_cnt <= '0;
    end else begin
      if (in_push) in_wp <= in_wp + AW'(1);
      if (in_pop)  in_rp <= in_rp + AW'(1);
      if (in_push & ~in_pop)      in_cnt <= in_cnt + (AW+1)'(1);
      else if (~in_push & in_pop) in_cnt <= in_cnt - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wp] <= net_di;
  end

  // ---------------------------------------------------------------
  // Per-VC output queues (PE -> router)
  // ---------------------------------------------------------------
  logic [PAC_WIDTH-1:0] vc_mem [2][DEPTH];
  logic [AW-1:0]        vc_wp  [2];
  logic [AW-1:0]        vc_rp  [2];
  logic [AW:0]          vc_cnt [2];
  logic [1:0]           vc_full, vc_push, vc_pop;
  logic                 sel, pe_wr, wr_vc, wr_drop;

  assign sel   = ~net_polarity;
  assign pe_wr = nicEn & nicWrEn & (addr == 2'b10);
  assign wr_vc = d_in[0];

  assign net_so = net_ro & (vc_cnt[sel] != '0);
  assign net_do = (vc_cnt[sel] != '0) ? vc_mem[sel][vc_rp[sel]] : '0;

  // A write to a full queue is dropped on the registered count, even if
  // the router pops that same queue this cycle.
  assign wr_drop = pe_wr & vc_full[wr_vc];

  always_comb begin
    vc_full = '0;
    vc_push = '0;
    vc_pop  = '0;
    for (int unsigned v = 0; v < 2; v++) begin
      vc_full[v] = (vc_cnt[v] == FULL_CNT);
      vc_push[v] = pe_wr & (wr_vc == 1'(v)) & ~vc_full[v];
      vc_pop[v]  = net_so & (sel == 1'(v));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned v = 0; v < 2; v++) begin
        vc_wp[v]  <= '0;
        vc_rp[v]  <= '0;
        vc_cnt[v] <= '0;
      end
    end else begin
      for (int unsigned v = 0; v < 2; v++) begin
        if (vc_push[v]) vc_wp[v] <= vc_wp[v] + AW'(1);
        if (vc_pop[v])  vc_rp[v] <= vc_rp[v] + AW'(1);
        if (vc_push[v] & ~vc_pop[v])      vc_cnt[v] <= vc_cnt[v] + (AW+1)'(1);
        else if (~vc_push[v] & vc_pop[v]) vc_cnt[v] <= vc_cnt[v] - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned v = 0; v < 2; v++) begin
      if (vc_push[v]) vc_mem[v][vc_wp[v]] <= d_in;
    end
  end

  // ---------------------------------------------------------------
  // Overflow flags
  // ---------------------------------------------------------------
  logic in_ovf, out_ovf;

`ifdef CARDINAL_NIC_OVF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ovf  <= 1'b0;
      out_ovf <= 1'b0;
    end else begin
      if (net_si & in_full)                 in_ovf <= 1'b1;
      else if (pe_rd & (addr == 2'b01))     in_ovf <= 1'b0;
      if (wr_drop)                          out_ovf <= 1'b1;
      else if (pe_rd & (addr == 2'b11))     out_ovf <= 1'b0;
    end
  end
`else
  assign in_ovf  = 1'b0;
  assign out_ovf = 1'b0;
`endif

  // ---------------------------------------------------------------
  // PE read mux
  // ---------------------------------------------------------------
  always_comb begin
    d_out = '0;
    if (pe_rd) begin
      case (addr)
        2'b00: if (!in_empty) d_out = in_mem[in_rp];
        2'b01: begin
          d_out[PAC_WIDTH-1]    = ~in_empty;
          d_out[PAC_WIDTH-2]    = in_ovf;
          d_out[PAC_WIDTH-9 -: 8] = 8'(in_cnt);
        end
        2'b11: begin
          d_out[PAC_WIDTH-1] = vc_full[0];
          d_out[PAC_WIDTH-2] = vc_full[1];
          d_out[PAC_WIDTH-3] = out_ovf;
        end
        default: d_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cardinal_nic_vcq.sv
module tb_cardinal_nic_vcq;

  localparam int PW    = 64;
  localparam int DEPTH = 4;
`ifdef CARDINAL_NIC_OVF_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  logic          clk, reset;
  logic [1:0]    addr;
  logic [PW-1:0] d_in, d_out, net_di, net_do;
  logic          nicEn, nicWrEn, net_si, net_ri, net_so, net_ro, net_polarity;

  cardinal_nic_vcq #(.PAC_WIDTH(PW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ri(net_ri),
    .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_polarity(net_polarity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors = 0, miscompares = 0;

  // Reference model: plain queues plus two flags.
  logic [PW-1:0] in_q[$], q0[$], q1[$];
  logic m_in_ovf = 1'b0, m_out_ovf = 1'b0;

  typedef struct {
    logic [1:0]    addr;
    logic [PW-1:0] din;
    logic          en, wr, si;
    logic [PW-1:0] di;
    logic          ro, pol;
    logic          e_ri, e_so;
    logic [PW-1:0] e_do, e_dout;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] a, input logic [PW-1:0] din,
                              input logic en, wr, si, input logic [PW-1:0] di,
                              input logic ro, pol, e_ri, e_so,
                              input logic [PW-1:0] e_do, e_dout);
    vec_t v;
    v.addr = a; v.din = din; v.en = en; v.wr = wr; v.si = si; v.di = di;
    v.ro = ro; v.pol = pol; v.e_ri = e_ri; v.e_so = e_so;
    v.e_do = e_do; v.e_dout = e_dout;
    return v;
  endfunction

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input logic v);
    return v ? q1.size() : q0.size();
  endfunction

  function automatic logic [PW-1:0] qhead(input logic v);
    return v ? q1[0] : q0[0];
  endfunction

  task automatic model_expect(output logic e_ri, e_so, output logic [PW-1:0] e_do, e_dout);
    logic s;
    s      = ~net_polarity;
    e_ri   = (in_q.size() != DEPTH);
    e_so   = net_ro && (qsize(s) != 0);
    e_do   = (qsize(s) != 0) ? qhead(s) : '0;
    e_dout = '0;
    if (nicEn && !nicWrEn) begin
      case (addr)
        2'd0: if (in_q.size() != 0) e_dout = in_q[0];
        2'd1: e_dout = {in_q.size() != 0, m_in_ovf, 6'b0, 8'(in_q.size()), 48'b0};
        2'd3: e_dout = {qsize(1'b0) == DEPTH, qsize(1'b1) == DEPTH, m_out_ovf, 61'b0};
        default: e_dout = '0;
      endcase
    end
  endtask

  task automatic model_update();
    logic rd, in_full, s, so, vc, wr, drop;
    rd      = nicEn && !nicWrEn;
    in_full = (in_q.size() == DEPTH);
    s       = ~net_polarity;
    so      = net_ro && (qsize(s) != 0);
    vc      = d_in[0];
    wr      = nicEn && nicWrEn && (addr == 2'd2);
    drop    = wr && (qsize(vc) == DEPTH);
    if (rd && addr == 2'd0 && in_q.size() != 0) void'(in_q.pop_front());
    if (net_si && !in_full) in_q.push_back(net_di);
    if (so) begin
      if (s) void'(q1.pop_front());
      else   void'(q0.pop_front());
    end
    if (wr && !drop) begin
      if (vc) q1.push_back(d_in);
      else    q0.push_back(d_in);
    end
`ifdef CARDINAL_NIC_OVF_EN
    if (net_si && in_full)          m_in_ovf = 1'b1;
    else if (rd && addr == 2'd1)    m_in_ovf = 1'b0;
    if (drop)                       m_out_ovf = 1'b1;
    else if (rd && addr == 2'd3)    m_out_ovf = 1'b0;
`endif
  endtask

  task automatic drive(input vec_t v);
    addr = v.addr; d_in = v.din; nicEn = v.en; nicWrEn = v.wr;
    net_si = v.si; net_di = v.di; net_ro = v.ro; net_polarity = v.pol;
  endtask

  // Called just after a rising edge: drive, compare on the falling edge,
  // advance the model on the next rising edge.
  task automatic run_vec(input vec_t v, input logic use_tab, input string tag);
    logic e_ri, e_so;
    logic [PW-1:0] e_do, e_dout;
    drive(v);
    @(negedge clk);
    if (use_tab) begin
      e_ri = v.e_ri; e_so = v.e_so; e_do = v.e_do; e_dout = v.e_dout;
    end else begin
      model_expect(e_ri, e_so, e_do, e_dout);
    end
    check({tag, ".net_ri"}, PW'(net_ri), PW'(e_ri));
    check({tag, ".net_so"}, PW'(net_so), PW'(e_so));
    check({tag, ".net_do"}, net_do, e_do);
    check({tag, ".d_out"},  d_out,  e_dout);
    @(posedge clk);
    model_update();
    #1;
  endtask

  localparam logic [PW-1:0] ZERO = '0;
  localparam logic [PW-1:0] ST4  = 64'h8004_0000_0000_0000;
  localparam logic [PW-1:0] FUL0 = 64'h8000_0000_0000_0000;

  vec_t tab[$];
  vec_t v;
  logic [PW-1:0] a [1:5];
  logic [PW-1:0] b [0:4];
  logic [PW-1:0] c1, ovf62, ovf61;

  initial begin
    for (int i = 1; i <= 5; i++) a[i] = 64'hAAAA_0000_0000_0000 | PW'(i);
    for (int i = 0; i <= 4; i++) b[i] = 64'hB000_0000_0000_0000 | PW'(i << 4);
    c1    = 64'hC000_0000_0000_0001;
    ovf62 = {1'b0, OVF, 62'b0};
    ovf61 = {2'b0, OVF, 61'b0};

    //            addr din   en wr si di    ro pol | ri so do    dout
    tab.push_back(mk(2'd0, ZERO, 0, 0, 0, ZERO, 0, 0, 1, 0, ZERO, ZERO));  // reset state
    for (int i = 1; i <= 4; i++)
      tab.push_back(mk(2'd0, ZERO, 0, 0, 1, a[i], 0, 0, 1, 0, ZERO, ZERO));
    tab.push_back(mk(2'd0, ZERO, 0, 0, 1, a[5], 0, 0, 0, 0, ZERO, ZERO));   // push into full
    tab.push_back(mk(2'd1, ZERO, 1, 0, 0, ZERO, 0, 0, 0, 0, ZERO, ST4 | ovf62));
    tab.push_back(mk(2'd1, ZERO, 1, 0, 0, ZERO, 0, 0, 0, 0, ZERO, ST4));
    tab.push_back(mk(2'd0, ZERO, 1, 0, 0, ZERO, 0, 0, 0, 0, ZERO, a[1]));
    for (int i = 2; i <= 4; i++)
      tab.push_back(mk(2'd0, ZERO, 1, 0, 0, ZERO, 0, 0, 1, 0, ZERO, a[i]));
    tab.push_back(mk(2'd0, ZERO, 1, 0, 0, ZERO, 0, 0, 1, 0, ZERO, ZERO));   // empty read
    tab.push_back(mk(2'd1, ZERO, 1, 0, 0, ZERO, 0, 0, 1, 0, ZERO, ZERO));
    for (int i = 0; i <= 3; i++)
      tab.push_back(mk(2'd2, b[i], 1, 1, 0, ZERO, 0, 0, 1, 0, ZERO, ZERO));
    tab.push_back(mk(2'd2, c1,   1, 1, 0, ZERO, 0, 0, 1, 0, ZERO, ZERO));
    tab.push_back(mk(2'd0, ZERO, 0, 0, 0, ZERO, 1, 0, 1, 1, c1,   ZERO));   // only VC1 goes
    tab.push_back(mk(2'd0, ZERO, 0, 0, 0, ZERO, 1, 0, 1, 0, ZERO, ZERO));
    tab.push_back(mk(2'd3, ZERO, 1, 0, 0, ZERO, 0, 1, 1, 0, b[0], FUL0));
    tab.push_back(mk(2'd2, b[4], 1, 1, 0, ZERO, 1, 1, 1, 1, b[0], ZERO));   // drop despite pop
    tab.push_back(mk(2'd3, ZERO, 1, 0, 0, ZERO, 1, 1, 1, 1, b[1], ovf61));
    tab.push_back(mk(2'd3, ZERO, 1, 0, 0, ZERO, 1, 1, 1, 1, b[2], ZERO));
    tab.push_back(mk(2'd0, ZERO, 0, 0, 0, ZERO, 1, 1, 1, 1, b[3], ZERO));
    tab.push_back(mk(2'd0, ZERO, 0, 0, 0, ZERO, 1, 1, 1, 0, ZERO, ZERO));   // B4 never appears

    reset = 1'b0;
    drive(mk(2'd0, ZERO, 0, 0, 0, ZERO, 0, 0, 0, 0, ZERO, ZERO));
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < tab.size(); i++) run_vec(tab[i], 1'b1, $sformatf("tab%0d", i));

    // Concurrent router push and PE pop at occupancy 2, wrapping pointers.
    for (int i = 0; i < 2; i++)
      run_vec(mk(2'd0, ZERO, 0, 0, 1, 64'hD000_0000_0000_0000 | PW'(i), 0, 0, 0, 0, ZERO, ZERO), 1'b0, "fill2");
    for (int i = 2; i < 12; i++)
      run_vec(mk(2'd0, ZERO, 1, 0, 1, 64'hD000_0000_0000_0000 | PW'(i), 0, 0, 0, 0, ZERO, ZERO), 1'b0, "pushpop");
    run_vec(mk(2'd1, ZERO, 1, 0, 0, ZERO, 0, 0, 0, 0, ZERO, ZERO), 1'b0, "cnt2");
    @(negedge clk);
    check("cnt_stays_2", PW'(d_out[55:48]), PW'(2));
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++)
      run_vec(mk(2'd0, ZERO, 1, 0, 0, ZERO, 0, 0, 0, 0, ZERO, ZERO), 1'b0, "drain");

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 2; i++)
      run_vec(mk(2'd2, 64'hE000_0000_0000_0000 | PW'(i << 4), 1, 1, 1, 64'hF000_0000_0000_0000 | PW'(i), 0, 1, 0, 0, ZERO, ZERO), 1'b0, "preburst");
    v = mk(2'd0, ZERO, 0, 0, 1, 64'hF000_0000_0000_0009, 1, 1, 0, 0, ZERO, ZERO);
    drive(v);
    @(negedge clk);
    check("burst.net_so", PW'(net_so), PW'(1));
    #2 reset = 1'b0;
    #1;
    check("rst.net_so", PW'(net_so), PW'(0));
    check("rst.net_ri", PW'(net_ri), PW'(1));
    check("rst.net_do", net_do, ZERO);
    in_q.delete(); q0.delete(); q1.delete();
    m_in_ovf = 1'b0; m_out_ovf = 1'b0;
    drive(mk(2'd0, ZERO, 0, 0, 0, ZERO, 0, 0, 0, 0, ZERO, ZERO));
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    run_vec(mk(2'd0, ZERO, 1, 0, 0, ZERO, 1, 1, 1, 0, ZERO, ZERO), 1'b1, "post0");
    run_vec(mk(2'd1, ZERO, 1, 0, 0, ZERO, 1, 0, 1, 0, ZERO, ZERO), 1'b1, "post1");

    // Randomised traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      v = mk(2'($urandom_range(0, 3)), {$urandom, $urandom}, $urandom_range(0, 3) != 0,
             1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0, {$urandom, $urandom},
             $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), 0, 0, ZERO, ZERO);
      run_vec(v, 1'b0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
